// File: rtl/midi_event_rx.sv
// -----------------------------------------------------------------------------
// midi_event_rx
//   MIDI receiver. The serial line is synchronised and decoded by an
//   oversampling UART. A running-status parser turns the bytes into note-off,
//   note-on and control-change events for the channels enabled in
//   CHANNEL_MASK. Events are queued in a first-word-fall-through FIFO and
//   presented on a valid/ready stream.
//
// Ports
//   clk          system clock
//   rst          synchronous reset, active-high
//   rx           asynchronous MIDI serial line, idle high
//   ev_valid     FIFO head valid
//   ev_ready     consumer accepts head when ev_valid && ev_ready
//   ev_type      0 note-off, 1 note-on, 2 control-change
//   ev_channel   MIDI channel 0..15
//   ev_note      note - NOTE_BASE (mod 2^NOTE_BITS), or controller number
//   ev_data      velocity or controller value
//   status       current running status byte (0 = none)
//   framing_err  1-cycle pulse: stop bit sampled low
//   overflow     1-cycle pulse: event dropped because the FIFO was full
// -----------------------------------------------------------------------------
module midi_event_rx #(
  parameter int unsigned CLK_HZ       = 100_000_000,
  parameter int unsigned BAUD         = 31250,
  parameter int unsigned NOTE_BASE    = 41,
  parameter int unsigned NOTE_BITS    = 7,
  parameter int unsigned FIFO_DEPTH   = 8,
  parameter logic [15:0] CHANNEL_MASK = 16'hFFFF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic                 ev_valid,
  input  logic                 ev_ready,
  output logic [1:0]           ev_type,
  output logic [3:0]           ev_channel,
  output logic [NOTE_BITS-1:0] ev_note,
  output logic [6:0]           ev_data,
  output logic [7:0]           status,
  output logic                 framing_err,
  output logic                 overflow
);

  localparam int unsigned PERIOD = CLK_HZ / BAUD;
  localparam int unsigned HALF   = PERIOD / 2;
  localparam int unsigned CW     = $clog2(PERIOD);
  localparam int unsigned PW     = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_state_t;

  typedef struct packed {
    logic [1:0]           kind;
    logic [3:0]           channel;
    logic [NOTE_BITS-1:0] note;
    logic [6:0]           data;
  } event_t;

  // ---------------------------------------------------------------------------
  // Input synchroniser (reset to the idle level so no false start appears)
  // ---------------------------------------------------------------------------
  logic r_sync1, r_sync2;
  logic w_rx;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its inputs regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rx;
      r_sync2 <= r_sync1;
    end
  end

  assign w_rx = r_sync2;

  // ---------------------------------------------------------------------------
  // UART receiver
  // ---------------------------------------------------------------------------
  uart_state_t r_state;
  logic        r_armed;
  logic [CW-1:0] r_cnt;
  logic [2:0]  r_bit_idx;
  logic [7:0]  r_shift;
  logic        r_byte_valid;
  logic        r_framing_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_armed       <= 1'b0;
      r_cnt         <= '0;
      r_bit_idx     <= '0;
      r_shift       <= '0;
      r_byte_valid  <= 1'b0;
      r_framing_err <= 1'b0;
    end else begin
      r_byte_valid  <= 1'b0;
      r_framing_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // A line held low (e.g. after a break) must go high before a start
          // edge is trusted.
          if (!r_armed) begin
            if (w_rx) r_armed <= 1'b1;
          end else if (!w_rx) begin
            r_state <= S_START;
            r_cnt   <= '0;
          end
        end
        S_START: begin
          if (r_cnt == CW'(HALF - 1)) begin
            r_cnt <= '0;
            if (!w_rx) begin
              r_state   <= S_DATA;
              r_bit_idx <= '0;
            end else begin
              r_state <= S_IDLE;
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_DATA: begin
          if (r_cnt == CW'(PERIOD - 1)) begin
            r_cnt     <= '0;
            r_shift   <= {w_rx, r_shift[7:1]};
            r_bit_idx <= r_bit_idx + 3'd1;
            if (r_bit_idx == 3'd7) r_state <= S_STOP;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_STOP: begin
          if (r_cnt == CW'(PERIOD - 1)) begin
            r_cnt   <= '0;
            r_state <= S_IDLE;
            if (w_rx) begin
              r_byte_valid <= 1'b1;
            end else begin
              r_framing_err <= 1'b1;
              r_armed       <= 1'b0;
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Running-status parser
  // ---------------------------------------------------------------------------
  logic [7:0] r_status;
  logic       r_second;   // next data byte is the second of a 2-byte message
  logic [6:0] r_d1;
  logic       r_push;
  event_t     r_ev;
  event_t     w_new_ev;

  // NOTE: every combinational output gets a default first so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    w_new_ev         = '0;
    w_new_ev.channel = r_status[3:0];
    w_new_ev.data    = r_shift[6:0];
    case (r_status[7:4])
      4'h8: begin
        w_new_ev.kind = 2'd0;
        w_new_ev.note = NOTE_BITS'(r_d1) - NOTE_BITS'(NOTE_BASE);
      end
      4'h9: begin
        // Velocity 0 on a note-on is a note-off.
        w_new_ev.kind = (r_shift[6:0] == 7'd0) ? 2'd0 : 2'd1;
        w_new_ev.note = NOTE_BITS'(r_d1) - NOTE_BITS'(NOTE_BASE);
      end
      4'hB: begin
        w_new_ev.kind = 2'd2;
        w_new_ev.note = NOTE_BITS'(r_d1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_status <= '0;
      r_second <= 1'b0;
      r_d1     <= '0;
      r_push   <= 1'b0;
      r_ev     <= '0;
    end else begin
      r_push <= 1'b0;
      if (r_byte_valid) begin
        if (r_shift[7]) begin
          // Realtime bytes (F8-FF) may interleave anywhere and are transparent.
          if (r_shift[7:3] != 5'b11111) begin
            r_second <= 1'b0;
            r_status <= (r_shift[7:4] == 4'hF) ? 8'h00 : r_shift;
          end
        end else if (r_status != 8'h00) begin
          case (r_status[7:4])
            4'h8, 4'h9, 4'hB: begin
              if (!r_second) begin
                r_d1     <= r_shift[6:0];
                r_second <= 1'b1;
              end else begin
                r_second <= 1'b0;
                r_ev     <= w_new_ev;
                r_push   <= CHANNEL_MASK[r_status[3:0]];
              end
            end
            4'hA, 4'hE: r_second <= !r_second;
            default: ;  // Cx/Dx carry a single discarded data byte
          endcase
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Event FIFO (first-word-fall-through)
  // ---------------------------------------------------------------------------
  event_t        r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_wr_ptr, r_rd_ptr;
  logic [PW:0]   r_count;
  logic          r_overflow;
  logic          w_pop, w_push_ok;
  event_t        w_head;

  assign ev_valid  = (r_count != '0);
  assign w_pop     = ev_valid && ev_ready;
  assign w_push_ok = r_push && ((r_count < (PW + 1)'(FIFO_DEPTH)) || w_pop);

  // NOTE: storage is deliberately not reset; r_count alone decides which
  // entries are meaningful, and outputs are gated while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= r_ev;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_overflow <= r_push && !w_push_ok;
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)     r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + (PW + 1)'(1);
        2'b01:   r_count <= r_count - (PW + 1)'(1);
        default: ;
      endcase
    end
  end

  assign w_head      = r_mem[r_rd_ptr];
  assign ev_type     = ev_valid ? w_head.kind    : '0;
  assign ev_channel  = ev_valid ? w_head.channel : '0;
  assign ev_note     = ev_valid ? w_head.note    : '0;
  assign ev_data     = ev_valid ? w_head.data    : '0;
  assign status      = r_status;
  assign framing_err = r_framing_err;
  assign overflow    = r_overflow;

endmodule

// File: tb/tb_midi_event_rx.sv
// -----------------------------------------------------------------------------
// tb_midi_event_rx
//   Directed bench for midi_event_rx. The clock is scaled so one MIDI bit is
//   16 system clocks. A second instance with CHANNEL_MASK = 16'h0001 shares
//   the serial line and always accepts, so its event count shows the mask.
// -----------------------------------------------------------------------------
module tb_midi_event_rx;

  localparam int unsigned BAUD   = 31250;
  localparam int unsigned BIT    = 16;
  localparam int unsigned CLK_HZ = BAUD * BIT;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic       ev_ready;
  logic       ev_valid;
  logic [1:0] ev_type;
  logic [3:0] ev_channel;
  logic [6:0] ev_note;
  logic [6:0] ev_data;
  logic [7:0] status;
  logic       framing_err;
  logic       overflow;

  logic       m_valid;
  logic [1:0] m_type;
  logic [3:0] m_channel;
  logic [6:0] m_note;
  logic [6:0] m_data;
  logic [7:0] m_status;
  logic       m_framing_err;
  logic       m_overflow;

  int n_checks = 0;
  int n_errors = 0;
  int ovf_cnt  = 0;
  int fe_cnt   = 0;
  int m_ev_cnt = 0;
  int snap;

  always #5 clk = ~clk;

  midi_event_rx #(
    .CLK_HZ(CLK_HZ), .BAUD(BAUD), .NOTE_BASE(41), .NOTE_BITS(7),
    .FIFO_DEPTH(8), .CHANNEL_MASK(16'hFFFF)
  ) dut (
    .clk(clk), .rst(rst), .rx(rx),
    .ev_valid(ev_valid), .ev_ready(ev_ready),
    .ev_type(ev_type), .ev_channel(ev_channel), .ev_note(ev_note),
    .ev_data(ev_data), .status(status),
    .framing_err(framing_err), .overflow(overflow)
  );

  midi_event_rx #(
    .CLK_HZ(CLK_HZ), .BAUD(BAUD), .NOTE_BASE(41), .NOTE_BITS(7),
    .FIFO_DEPTH(8), .CHANNEL_MASK(16'h0001)
  ) dut_m (
    .clk(clk), .rst(rst), .rx(rx),
    .ev_valid(m_valid), .ev_ready(1'b1),
    .ev_type(m_type), .ev_channel(m_channel), .ev_note(m_note),
    .ev_data(m_data), .status(m_status),
    .framing_err(m_framing_err), .overflow(m_overflow)
  );

  // Pulse and event monitors
  always @(posedge clk) begin
    if (overflow)    ovf_cnt  <= ovf_cnt + 1;
    if (framing_err) fe_cnt   <= fe_cnt + 1;
    if (m_valid)     m_ev_cnt <= m_ev_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    repeat (BIT) @(posedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit = 1'b1);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop_bit);
    send_bit(1'b1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask

  // Compare the FIFO head with an expected event, then pop it.
  task automatic expect_event(input string tag, input int t, input int c,
                              input int n, input int d);
    logic [19:0] exp_fields;
    exp_fields = {2'(t), 4'(c), 7'(n), 7'(d)};
    @(negedge clk);
    check({tag, ".valid"}, 32'(ev_valid), 32'd1);
    check({tag, ".fields"}, 32'({ev_type, ev_channel, ev_note, ev_data}),
          32'(exp_fields));
    ev_ready = 1'b1;
    @(negedge clk);
    ev_ready = 1'b0;
  endtask

  task automatic expect_empty(input string tag);
    @(negedge clk);
    check(tag, 32'(ev_valid), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    @(negedge clk);
    check({tag, ".outs"},
          32'({ev_valid, ev_type, ev_channel, ev_note, ev_data, framing_err, overflow}),
          32'd0);
    check({tag, ".status"}, 32'(status), 32'd0);
  endtask

  initial begin
    rx       = 1'b1;
    rst      = 1'b1;
    ev_ready = 1'b0;
    idle(5);
    check_all_zero("reset");
    rst = 1'b0;
    idle(2 * BIT);

    // 1: single note-on
    send_byte(8'h90); send_byte(8'h3C); send_byte(8'h64);
    idle(4);
    @(negedge clk);
    check("t1.status", 32'(status), 32'h90);
    expect_event("t1.ev", 1, 0, 19, 100);
    expect_empty("t1.empty");

    // 2: running status, velocity-0 note-on becomes note-off
    send_byte(8'h91); send_byte(8'h40); send_byte(8'h50);
    send_byte(8'h40); send_byte(8'h00);
    idle(4);
    expect_event("t2.ev0", 1, 1, 23, 80);
    expect_event("t2.ev1", 0, 1, 23, 0);
    expect_empty("t2.empty");

    // 3: control change with a realtime byte in the middle
    send_byte(8'hB2); send_byte(8'h07); send_byte(8'hF8);
    @(negedge clk);
    check("t3.status_rt", 32'(status), 32'hB2);
    send_byte(8'h7F);
    idle(4);
    expect_event("t3.ev", 2, 2, 7, 127);
    check("t3.status", 32'(status), 32'hB2);
    expect_empty("t3.empty");

    // 4: framing error, then a clean note-off
    snap = fe_cnt;
    send_byte(8'h90, 1'b0);
    idle(2 * BIT);
    @(negedge clk);
    check("t4.fe_pulses", 32'(fe_cnt - snap), 32'd1);
    check("t4.status", 32'(status), 32'hB2);
    check("t4.no_event", 32'(ev_valid), 32'd0);
    send_byte(8'h80); send_byte(8'h30); send_byte(8'h40);
    idle(4);
    expect_event("t4.ev", 0, 0, 7, 64);
    expect_empty("t4.empty");

    // 5: fill past capacity with the consumer stalled, then drain
    snap = ovf_cnt;
    for (int i = 0; i < 9; i++) begin
      send_byte(8'h90);
      send_byte(8'(41 + i));
      send_byte(8'(10 + i));
    end
    idle(4);
    @(negedge clk);
    check("t5.ovf_pulses", 32'(ovf_cnt - snap), 32'd1);
    for (int i = 0; i < 8; i++) expect_event($sformatf("t5.ev%0d", i), 1, 0, i, 10 + i);
    expect_empty("t5.empty");

    // 6: channel mask, then reset in the middle of a byte
    snap = m_ev_cnt;
    send_byte(8'h93); send_byte(8'h3C); send_byte(8'h64);
    idle(4);
    @(negedge clk);
    check("t6.mask_drop", 32'(m_ev_cnt - snap), 32'd0);
    check("t6.unmasked_valid", 32'(ev_valid), 32'd1);
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    rst = 1'b1;
    rx  = 1'b1;
    idle(4);
    check_all_zero("t6.reset");
    rst = 1'b0;
    idle(2 * BIT);
    snap = m_ev_cnt;
    send_byte(8'h90);
    @(negedge clk);
    check("t6.status", 32'(status), 32'h90);
    send_byte(8'h3C); send_byte(8'h64);
    idle(4);
    @(negedge clk);
    check("t6.mask_pass", 32'(m_ev_cnt - snap), 32'd1);
    expect_event("t6.ev", 1, 0, 19, 100);
    expect_empty("t6.empty");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
